// File: rtl/adder_seq_ctrl_pkg.sv
// rtl/adder_seq_ctrl_pkg.sv - shared types and constants for the nibble-serial adder controller
package adder_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// rtl/adder_seq_ctrl_if.sv - operand/sum valid-ready handshake bundle
interface adder_seq_ctrl_if #(
    parameter int NIBBLES = 2
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   sum;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, sum
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, sum
    );

endinterface

// File: rtl/adder_seq_ctrl_nibble_add.sv
// rtl/adder_seq_ctrl_nibble_add.sv - combinational 4-bit adder with carry in/out
module nibble_add
    import adder_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W:0]   res
);

    assign res = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - time-multiplexes one nibble adder over multi-nibble operands
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ena,
    adder_seq_ctrl_if.slave bus,
    output logic            busy
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);

    state_t             state;
    state_t             state_nx;
    logic [IDX_W-1:0]   idx;
    logic               cy;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W:0]         sum_q;
    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W:0]   add_res;
    logic               last;

    assign last = (idx == IDX_W'(NIBBLES - 1));

    // Operand mux: select the nibble currently being added.
    always_comb begin
        nib_a = a_q[idx*NIBBLE_W +: NIBBLE_W];
        nib_b = b_q[idx*NIBBLE_W +: NIBBLE_W];
    end

    nibble_add u_nibble_add (
        .a   (nib_a),
        .b   (nib_b),
        .cin (cy),
        .res (add_res)
    );

    // in_ready is gated by reset so nothing is offered while reset is held.
    assign bus.in_ready  = reset && ena && (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign busy          = (state != IDLE);

    // Next-state logic; every transition requires ena so a stall freezes the FSM.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (ena && bus.in_valid)  state_nx = ADD;
            ADD:  if (ena && last)          state_nx = DONE;
            DONE: if (ena && bus.out_ready) state_nx = IDLE;
            default:                        state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath: latch operands on accept, then write one sum nibble per enabled edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx   <= '0;
            cy    <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.op_a;
                        b_q   <= bus.op_b;
                        idx   <= '0;
                        cy    <= 1'b0;
                        sum_q <= '0;
                    end
                end
                ADD: begin
                    sum_q[idx*NIBBLE_W +: NIBBLE_W] <= add_res[NIBBLE_W-1:0];
                    cy <= add_res[NIBBLE_W];
                    if (last) begin
                        // Final carry becomes the sum MSB; idx parks at 0 for the next op.
                        sum_q[W] <= add_res[NIBBLE_W];
                        idx      <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - directed and back-to-back checks of adder_seq_ctrl
module tb_adder_seq_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic ena   = 1'b0;
    logic busy1, busy2, busy4;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    adder_seq_ctrl_if #(.NIBBLES(2)) ifc2 ();
    adder_seq_ctrl_if #(.NIBBLES(1)) ifc1 ();
    adder_seq_ctrl_if #(.NIBBLES(4)) ifc4 ();

    adder_seq_ctrl #(.NIBBLES(2)) dut2 (.clk(clk), .reset(reset), .ena(ena), .bus(ifc2), .busy(busy2));
    adder_seq_ctrl #(.NIBBLES(1)) dut1 (.clk(clk), .reset(reset), .ena(ena), .bus(ifc1), .busy(busy1));
    adder_seq_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .reset(reset), .ena(ena), .bus(ifc4), .busy(busy4));

    // Driver for one NIBBLES=2 operation with out_ready held high.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [8:0] s, output int lat, output bit ok);
        int w;
        ok = 1'b0;
        s  = '0;
        lat = 0;
        ifc2.op_a = a;
        ifc2.op_b = b;
        ifc2.in_valid  = 1'b1;
        ifc2.out_ready = 1'b1;
        #1;
        w = 0;
        while (!ifc2.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!ifc2.in_ready) begin
            ifc2.in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        ifc2.in_valid = 1'b0;
        while (!ifc2.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        ok = ifc2.out_valid;
        s  = ifc2.sum;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        ena   = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (ifc2.in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b want=0", ifc2.in_ready); else n_pass++;
        n_total++; if (ifc2.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", ifc2.out_valid); else n_pass++;
        n_total++; if (busy2 !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy2); else n_pass++;
        n_total++; if (ifc2.sum !== 9'h000) $display("FAIL reset_sum got=%h want=000", ifc2.sum); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_total++; if (ifc2.in_ready !== 1'b1) $display("FAIL release_in_ready got=%b want=1", ifc2.in_ready); else n_pass++;
        ena = 1'b0;
        #1;
        n_total++; if (ifc2.in_ready !== 1'b0) $display("FAIL idle_ena_low_in_ready got=%b want=0", ifc2.in_ready); else n_pass++;
        ena = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        ifc2.op_a = 8'h35;
        ifc2.op_b = 8'h0A;
        ifc2.in_valid  = 1'b1;
        ifc2.out_ready = 1'b1;
        #1;
        n_total++; if (ifc2.in_ready !== 1'b1) $display("FAIL basic_accept_ready got=%b want=1", ifc2.in_ready); else n_pass++;
        @(negedge clk);
        ifc2.in_valid = 1'b0;
        n_total++; if (busy2 !== 1'b1) $display("FAIL basic_busy got=%b want=1", busy2); else n_pass++;
        n_total++; if (ifc2.in_ready !== 1'b0) $display("FAIL basic_in_ready_c0 got=%b want=0", ifc2.in_ready); else n_pass++;
        n_total++; if (ifc2.out_valid !== 1'b0) $display("FAIL basic_out_valid_c0 got=%b want=0", ifc2.out_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (ifc2.out_valid !== 1'b0) $display("FAIL basic_out_valid_c1 got=%b want=0", ifc2.out_valid); else n_pass++;
        n_total++; if (ifc2.in_ready !== 1'b0) $display("FAIL basic_in_ready_c1 got=%b want=0", ifc2.in_ready); else n_pass++;
        @(negedge clk);
        n_total++; if (ifc2.out_valid !== 1'b1) $display("FAIL basic_out_valid_c2 got=%b want=1", ifc2.out_valid); else n_pass++;
        n_total++; if (ifc2.sum !== 9'h03F) $display("FAIL basic_sum got=%h want=03f", ifc2.sum); else n_pass++;
        n_total++; if (ifc2.in_ready !== 1'b0) $display("FAIL basic_in_ready_done got=%b want=0", ifc2.in_ready); else n_pass++;
        @(negedge clk);
        n_total++; if (ifc2.out_valid !== 1'b0) $display("FAIL basic_out_valid_after got=%b want=0", ifc2.out_valid); else n_pass++;
        n_total++; if (ifc2.in_ready !== 1'b1) $display("FAIL basic_in_ready_after got=%b want=1", ifc2.in_ready); else n_pass++;
        n_total++; if (busy2 !== 1'b0) $display("FAIL basic_busy_after got=%b want=0", busy2); else n_pass++;
    endtask

    task automatic test_carry;
        logic [8:0] s;
        int lat;
        bit ok;
        run_op(8'hFF, 8'hFF, s, lat, ok);
        n_total++; if (!ok || s !== 9'h1FE) $display("FAIL carry_all_ones got=%h ok=%0d want=1fe", s, ok); else n_pass++;
        n_total++; if (lat != 2) $display("FAIL carry_latency got=%0d want=2", lat); else n_pass++;
        run_op(8'h0F, 8'h01, s, lat, ok);
        n_total++; if (!ok || s !== 9'h010) $display("FAIL carry_inter_nibble got=%h ok=%0d want=010", s, ok); else n_pass++;
        run_op(8'h00, 8'h00, s, lat, ok);
        n_total++; if (!ok || s !== 9'h000) $display("FAIL carry_zero got=%h ok=%0d want=000", s, ok); else n_pass++;
    endtask

    task automatic test_backpressure;
        int w;
        ifc2.out_ready = 1'b0;
        ifc2.op_a = 8'h21;
        ifc2.op_b = 8'h43;
        ifc2.in_valid = 1'b1;
        @(negedge clk);
        ifc2.in_valid = 1'b0;
        w = 0;
        while (!ifc2.out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_total++; if (!ifc2.out_valid) $display("FAIL bp_timeout got=0 want=out_valid"); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                ifc2.in_valid = 1'b1;
                ifc2.op_a = 8'hAA;
                ifc2.op_b = 8'h11;
            end else begin
                ifc2.in_valid = 1'b0;
            end
            #1;
            n_total++; if (ifc2.out_valid !== 1'b1) $display("FAIL bp_out_valid_%0d got=%b want=1", i, ifc2.out_valid); else n_pass++;
            n_total++; if (ifc2.sum !== 9'h064) $display("FAIL bp_sum_%0d got=%h want=064", i, ifc2.sum); else n_pass++;
            n_total++; if (ifc2.in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d got=%b want=0", i, ifc2.in_ready); else n_pass++;
            @(negedge clk);
        end
        ifc2.in_valid  = 1'b0;
        ifc2.out_ready = 1'b1;
        @(negedge clk);
        n_total++; if (ifc2.out_valid !== 1'b0) $display("FAIL bp_release_out_valid got=%b want=0", ifc2.out_valid); else n_pass++;
        n_total++; if (ifc2.in_ready !== 1'b1) $display("FAIL bp_release_in_ready got=%b want=1", ifc2.in_ready); else n_pass++;
        @(negedge clk);
        n_total++; if (busy2 !== 1'b0) $display("FAIL bp_pulse_not_queued busy=%b want=0", busy2); else n_pass++;
    endtask

    task automatic test_stall;
        int lat;
        ifc2.op_a = 8'h5A;
        ifc2.op_b = 8'h6B;
        ifc2.in_valid  = 1'b1;
        ifc2.out_ready = 1'b1;
        #1;
        n_total++; if (ifc2.in_ready !== 1'b1) $display("FAIL stall_accept_ready got=%b want=1", ifc2.in_ready); else n_pass++;
        @(negedge clk);
        ifc2.in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        lat++;
        ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            lat++;
            n_total++; if (ifc2.in_ready !== 1'b0) $display("FAIL stall_in_ready_%0d got=%b want=0", lat, ifc2.in_ready); else n_pass++;
            n_total++; if (ifc2.out_valid !== 1'b0) $display("FAIL stall_out_valid_%0d got=%b want=0", lat, ifc2.out_valid); else n_pass++;
        end
        ena = 1'b1;
        while (!ifc2.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_total++; if (lat != 5) $display("FAIL stall_latency got=%0d want=5", lat); else n_pass++;
        n_total++; if (ifc2.sum !== 9'h0C5) $display("FAIL stall_sum got=%h want=0c5", ifc2.sum); else n_pass++;
        @(negedge clk);
        n_total++; if (ifc2.in_ready !== 1'b1) $display("FAIL stall_in_ready_after got=%b want=1", ifc2.in_ready); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [8:0] s;
        int lat;
        bit ok;
        ifc2.op_a = 8'h77;
        ifc2.op_b = 8'h88;
        ifc2.in_valid = 1'b1;
        @(negedge clk);
        ifc2.in_valid = 1'b0;
        @(negedge clk);
        n_total++; if (ifc2.sum[3:0] !== 4'hF) $display("FAIL rstmid_low_nibble got=%h want=f", ifc2.sum[3:0]); else n_pass++;
        n_total++; if (busy2 !== 1'b1) $display("FAIL rstmid_busy_before got=%b want=1", busy2); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (ifc2.out_valid !== 1'b0) $display("FAIL rstmid_out_valid got=%b want=0", ifc2.out_valid); else n_pass++;
        n_total++; if (ifc2.sum !== 9'h000) $display("FAIL rstmid_sum got=%h want=000", ifc2.sum); else n_pass++;
        n_total++; if (busy2 !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", busy2); else n_pass++;
        n_total++; if (ifc2.in_ready !== 1'b0) $display("FAIL rstmid_in_ready got=%b want=0", ifc2.in_ready); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op(8'h12, 8'h34, s, lat, ok);
        n_total++; if (!ok || s !== 9'h046) $display("FAIL rstmid_new_op got=%h ok=%0d want=046", s, ok); else n_pass++;
    endtask

    task automatic test_back_to_back_n1;
        logic [4:0] q[$];
        logic [4:0] exp;
        int issued = 0;
        int got = 0;
        int cyc = 0;
        bit clr = 1'b0;
        ifc1.in_valid  = 1'b0;
        ifc1.out_ready = 1'b0;
        while (got < 20 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (clr) begin
                ifc1.in_valid = 1'b0;
                clr = 1'b0;
            end
            if (!ifc1.in_valid && issued < 20 && $urandom_range(3) != 0) begin
                ifc1.in_valid = 1'b1;
                ifc1.op_a = 4'($urandom);
                ifc1.op_b = 4'($urandom);
            end
            ifc1.out_ready = ($urandom_range(3) != 0);
            #1;
            if (ifc1.in_valid && ifc1.in_ready) begin
                q.push_back({1'b0, ifc1.op_a} + {1'b0, ifc1.op_b});
                issued++;
                clr = 1'b1;
            end
            if (ifc1.out_valid && ifc1.out_ready) begin
                n_total++;
                if (q.size() == 0) begin
                    $display("FAIL n1_unexpected_result got=%h want=none", ifc1.sum);
                end else begin
                    exp = q.pop_front();
                    if (ifc1.sum !== exp) $display("FAIL n1_sum_%0d got=%h want=%h", got, ifc1.sum, exp); else n_pass++;
                end
                got++;
            end
        end
        @(negedge clk);
        ifc1.in_valid  = 1'b0;
        ifc1.out_ready = 1'b0;
        n_total++;
        if (got != 20 || issued != 20 || q.size() != 0)
            $display("FAIL n1_count got=%0d issued=%0d pending=%0d want=20/20/0", got, issued, q.size());
        else
            n_pass++;
    endtask

    task automatic test_back_to_back_n4;
        logic [16:0] q[$];
        logic [16:0] exp;
        int issued = 0;
        int got = 0;
        int cyc = 0;
        bit clr = 1'b0;
        ifc4.in_valid  = 1'b0;
        ifc4.out_ready = 1'b0;
        while (got < 20 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (clr) begin
                ifc4.in_valid = 1'b0;
                clr = 1'b0;
            end
            if (!ifc4.in_valid && issued < 20 && $urandom_range(3) != 0) begin
                ifc4.in_valid = 1'b1;
                ifc4.op_a = (issued == 0) ? 16'hFFFF : 16'($urandom);
                ifc4.op_b = (issued == 0) ? 16'hFFFF : 16'($urandom);
            end
            ifc4.out_ready = ($urandom_range(3) != 0);
            #1;
            if (ifc4.in_valid && ifc4.in_ready) begin
                q.push_back({1'b0, ifc4.op_a} + {1'b0, ifc4.op_b});
                issued++;
                clr = 1'b1;
            end
            if (ifc4.out_valid && ifc4.out_ready) begin
                n_total++;
                if (q.size() == 0) begin
                    $display("FAIL n4_unexpected_result got=%h want=none", ifc4.sum);
                end else begin
                    exp = q.pop_front();
                    if (ifc4.sum !== exp) $display("FAIL n4_sum_%0d got=%h want=%h", got, ifc4.sum, exp); else n_pass++;
                end
                got++;
            end
        end
        @(negedge clk);
        ifc4.in_valid  = 1'b0;
        ifc4.out_ready = 1'b0;
        n_total++;
        if (got != 20 || issued != 20 || q.size() != 0)
            $display("FAIL n4_count got=%0d issued=%0d pending=%0d want=20/20/0", got, issued, q.size());
        else
            n_pass++;
    endtask

    initial begin
        ifc2.in_valid = 1'b0; ifc2.op_a = '0; ifc2.op_b = '0; ifc2.out_ready = 1'b0;
        ifc1.in_valid = 1'b0; ifc1.op_a = '0; ifc1.op_b = '0; ifc1.out_ready = 1'b0;
        ifc4.in_valid = 1'b0; ifc4.op_a = '0; ifc4.op_b = '0; ifc4.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_back_to_back_n1();
        test_back_to_back_n4();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
